// File: rtl/secuenciador_pkg.sv
// Shared types and width helpers for the Booth-multiplier operand sequencer.
package secuenciador_pkg;

   // Sequencer states; the top module mirrors these as plain constants.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LANZAR  = 2'd1,
      ESPERA  = 2'd2,
      ENTREGA = 2'd3
   } estado_e;

   // Product width for an operand width of n bits.
   function automatic int prod_w(input int n);
      return 2 * n;
   endfunction

   // Fill-level width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Watchdog width: counts 0..timeout-1; timeout >= 2 keeps this >= 1.
   function automatic int wd_w(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/secuenciador_mult_fifo.sv
// Operand FIFO: stores {multiplicando, multiplicador} pairs, first-word
// fall-through read port, power-of-two depth so pointers wrap naturally.
module fifo_operandos
   import secuenciador_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       dato_i,
   output logic [WIDTH-1:0]       dato_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dato_o  = mem_q[rd_ptr_q];

   // Guard against overflow/underflow regardless of what the caller does.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointer and fill-level next state; simultaneous push+pop leaves count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; cleared on reset so stale pairs never reappear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= dato_i;
      end
   end

endmodule

// File: rtl/secuenciador_mult.sv
// Operand sequencer in front of the sequential Booth multiplier: buffers
// operand pairs, launches one multiplication at a time, waits for the rising
// edge of Fin, and returns the product with echoed operands. A watchdog
// abandons operations whose Fin never arrives.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a queued pair; pops and loads operands
//   LANZAR  | mult_start high for this single cycle, watchdog cleared
//   ESPERA  | operands held, waiting for Fin rise or watchdog expiry
//   ENTREGA | result presented on out_*, waiting for out_ready
module secuenciador_mult
   import secuenciador_pkg::*;
#(
   parameter int NUM_BITS       = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_BITS-1:0]         in_multiplicando,
   input  logic [NUM_BITS-1:0]         in_multiplicador,
   output logic [NUM_BITS-1:0]         mult_multiplicando,
   output logic [NUM_BITS-1:0]         mult_multiplicador,
   output logic                        mult_start,
   input  logic [2*NUM_BITS-1:0]       mult_resultado,
   input  logic                        mult_fin,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2*NUM_BITS-1:0]       out_resultado,
   output logic [NUM_BITS-1:0]         out_multiplicando,
   output logic [NUM_BITS-1:0]         out_multiplicador,
   output logic [$clog2(FIFO_DEPTH):0] ocupacion,
   output logic                        err_timeout
);
   localparam int PROD_W = prod_w(NUM_BITS);
   localparam int CNT_W  = cnt_w(FIFO_DEPTH);
   localparam int WD_W   = wd_w(TIMEOUT_CYCLES);

   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_LANZAR  = LANZAR;
   localparam logic [1:0] S_ESPERA  = ESPERA;
   localparam logic [1:0] S_ENTREGA = ENTREGA;

   logic [1:0]          estado_q, estado_d;
   logic [NUM_BITS-1:0] mult_a_q, mult_a_d;
   logic [NUM_BITS-1:0] mult_b_q, mult_b_d;
   logic                start_q, start_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                fin_q;
   logic                out_valid_q, out_valid_d;
   logic [PROD_W-1:0]   out_res_q, out_res_d;
   logic [NUM_BITS-1:0] out_a_q, out_a_d;
   logic [NUM_BITS-1:0] out_b_q, out_b_d;
   logic                err_q, err_d;

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [PROD_W-1:0]   fifo_din, fifo_dout;
   logic [CNT_W-1:0]    fifo_count;
   logic                fin_rise;

   assign fifo_din  = {in_multiplicando, in_multiplicador};
   assign fifo_push = in_valid && !fifo_full;
   assign fifo_pop  = (estado_q == S_IDLE) && !fifo_empty;

   fifo_operandos #(
      .WIDTH (PROD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .dato_i  (fifo_din),
      .dato_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Fin is a level; only its rising edge inside ESPERA counts as completion.
   assign fin_rise = mult_fin && !fin_q;

   assign in_ready           = !fifo_full;
   assign ocupacion          = fifo_count;
   assign mult_multiplicando = mult_a_q;
   assign mult_multiplicador = mult_b_q;
   assign mult_start         = start_q;
   assign out_valid          = out_valid_q;
   assign out_resultado      = out_res_q;
   assign out_multiplicando  = out_a_q;
   assign out_multiplicador  = out_b_q;
   assign err_timeout        = err_q;

   // Sequencing FSM and datapath next-state.
   always_comb begin
      estado_d    = estado_q;
      mult_a_d    = mult_a_q;
      mult_b_d    = mult_b_q;
      start_d     = 1'b0;
      wd_d        = wd_q;
      out_valid_d = out_valid_q;
      out_res_d   = out_res_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      err_d       = err_q;
      case (estado_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               mult_a_d = fifo_dout[PROD_W-1:NUM_BITS];
               mult_b_d = fifo_dout[NUM_BITS-1:0];
               start_d  = 1'b1;
               estado_d = S_LANZAR;
            end
         end
         S_LANZAR: begin
            wd_d     = '0;
            estado_d = S_ESPERA;
         end
         S_ESPERA: begin
            // A Fin edge on the last allowed cycle still counts as success.
            if (fin_rise) begin
               out_res_d   = mult_resultado;
               out_a_d     = mult_a_q;
               out_b_d     = mult_b_q;
               out_valid_d = 1'b1;
               estado_d    = S_ENTREGA;
            end else if (wd_q == WD_LIMIT) begin
               err_d    = 1'b1;
               estado_d = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_ENTREGA: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               estado_d    = S_IDLE;
            end
         end
         default: estado_d = S_IDLE;
      endcase
   end

   // State, operand, watchdog and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= S_IDLE;
         mult_a_q    <= '0;
         mult_b_q    <= '0;
         start_q     <= 1'b0;
         wd_q        <= '0;
         fin_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         mult_a_q    <= mult_a_d;
         mult_b_q    <= mult_b_d;
         start_q     <= start_d;
         wd_q        <= wd_d;
         fin_q       <= mult_fin;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_secuenciador_mult.sv
// Bench for secuenciador_mult: scoreboard of hand-computed results checked by
// a monitor on each output handshake, plus a simple multiplier model.
module tb_secuenciador_mult;
   localparam int NB = 3;
   localparam int PW = 6;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] in_multiplicando = '0;
   logic [NB-1:0] in_multiplicador = '0;
   logic [NB-1:0] mult_multiplicando;
   logic [NB-1:0] mult_multiplicador;
   logic          mult_start;
   logic [PW-1:0] mult_resultado = '0;
   logic          mult_fin = 1'b1;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [PW-1:0] out_resultado;
   logic [NB-1:0] out_multiplicando;
   logic [NB-1:0] out_multiplicador;
   logic [CW-1:0] ocupacion;
   logic          err_timeout;

   secuenciador_mult #(.NUM_BITS(3), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_multiplicando   (in_multiplicando),
      .in_multiplicador   (in_multiplicador),
      .mult_multiplicando (mult_multiplicando),
      .mult_multiplicador (mult_multiplicador),
      .mult_start         (mult_start),
      .mult_resultado     (mult_resultado),
      .mult_fin           (mult_fin),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_resultado      (out_resultado),
      .out_multiplicando  (out_multiplicando),
      .out_multiplicador  (out_multiplicador),
      .ocupacion          (ocupacion),
      .err_timeout        (err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [PW-1:0] res;
      logic [NB-1:0] a;
      logic [NB-1:0] b;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Multiplier model: Fin rises fin_delay cycles after a start pulse.
   int fin_delay = 6;
   int skip_fin = 0;
   int cnt_dn = 0;
   int starts = 0;
   int last_start_cyc = -1;
   int fin_cyc = -100;
   bit prev_start = 1'b0;
   logic signed [PW-1:0] pa, pb;

   always @(negedge clk) begin
      if (mult_start) begin
         starts++;
         last_start_cyc = cyc;
         if (prev_start) begin
            tests++;
            fails++;
            $display("FAIL start_pulse_width: start high on consecutive cycles at %0d", cyc);
         end
         mult_fin = 1'b0;
         if (skip_fin > 0) begin
            skip_fin--;
            cnt_dn = 0;
         end else begin
            cnt_dn = fin_delay;
            pa = PW'($signed(mult_multiplicando));
            pb = PW'($signed(mult_multiplicador));
            mult_resultado = pa * pb;
         end
      end else if (cnt_dn > 0) begin
         cnt_dn--;
         if (cnt_dn == 0) begin
            mult_fin = 1'b1;
            fin_cyc  = cyc;
         end
      end
      prev_start = mult_start;
   end

   // Monitor: checks latency on each out_valid rise, pops and compares on handshake.
   bit   prev_ov = 1'b0;
   int   hs_cyc = -1;
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: out_valid with res %0h, nothing expected", out_resultado);
            end else begin
               check("out_latency", cyc, fin_cyc + 1);
            end
         end
         if (out_valid && out_ready && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("out_resultado", out_resultado, mon_e.res);
            check("out_multiplicando", out_multiplicando, mon_e.a);
            check("out_multiplicador", out_multiplicador, mon_e.b);
            hs_cyc = cyc + 1;
         end
         prev_ov = out_valid;
      end
   end

   int last_push = 0;

   task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [PW-1:0] r, input bit chk);
      int n = 0;
      exp_t e;
      in_multiplicando = a;
      in_multiplicador = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL push_wait: in_ready never rose for pair %0h,%0h", a, b);
      end else if (chk) begin
         e.res = r;
         e.a   = a;
         e.b   = b;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      last_push = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_start(input int n0, input int budget);
      int n = 0;
      while (starts <= n0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("start_seen", starts > n0, 1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int s0, lst;
      logic [PW+2*NB:0] snap;

      // 1: reset with Fin high
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_mult_start", mult_start, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_ocupacion", ocupacion, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_out_resultado", out_resultado, 0);
      check("rst_mult_ops", {mult_multiplicando, mult_multiplicador}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("no_start_after_rst", starts, 0);
      check("no_out_after_rst", out_valid, 0);

      // 2: single operation (-3, 2) -> -6
      fin_delay = 6;
      s0 = starts;
      push(3'b101, 3'b010, 6'b111010, 1'b1);
      wait_start(s0, 20);
      check("start_latency", last_start_cyc + 1, last_push + 2);
      wait_drain(60);

      // 3: FIFO fills while the multiplier is busy
      fin_delay = 15;
      s0 = starts;
      push(3'b001, 3'b001, 6'b000001, 1'b1);
      wait_start(s0, 20);
      push(3'b100, 3'b100, 6'b010000, 1'b1);
      push(3'b011, 3'b011, 6'b001001, 1'b1);
      push(3'b111, 3'b011, 6'b111101, 1'b1);
      push(3'b010, 3'b110, 6'b111100, 1'b1);
      check("full_ocupacion", ocupacion, 4);
      check("full_in_ready", in_ready, 0);
      push(3'b110, 3'b110, 6'b000100, 1'b1);
      wait_drain(400);

      // 4: backpressure on the output
      fin_delay = 6;
      out_ready = 1'b0;
      push(3'b001, 3'b011, 6'b000011, 1'b1);
      push(3'b110, 3'b111, 6'b000010, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      check("bp_out_valid", out_valid, 1);
      snap = {out_valid, out_resultado, out_multiplicando, out_multiplicador};
      s0 = starts;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", {out_valid, out_resultado, out_multiplicando, out_multiplicador}, snap);
      end
      check("bp_no_start", starts, s0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_start(s0, 20);
      check("restart_gap", last_start_cyc + 1, hs_cyc + 2);
      wait_drain(60);

      // 5: watchdog expiry, then the next pair completes
      skip_fin = 1;
      s0 = starts;
      push(3'b001, 3'b001, 6'b000001, 1'b0);
      push(3'b010, 3'b101, 6'b111010, 1'b1);
      wait_start(s0, 20);
      lst = last_start_cyc;
      while (cyc < lst + 64) @(negedge clk);
      check("tmo_not_yet", err_timeout, 0);
      @(negedge clk);
      check("tmo_set", err_timeout, 1);
      check("tmo_no_out", out_valid, 0);
      wait_drain(100);
      check("tmo_sticky", err_timeout, 1);

      // 6: reset in the middle of ESPERA with entries queued
      fin_delay = 30;
      s0 = starts;
      push(3'b001, 3'b010, 6'b000010, 1'b0);
      wait_start(s0, 20);
      push(3'b011, 3'b001, 6'b000011, 1'b0);
      push(3'b101, 3'b101, 6'b001001, 1'b0);
      push(3'b111, 3'b111, 6'b000001, 1'b0);
      check("mid_ocupacion", ocupacion, 3);
      rst_n = 1'b0;
      #2;
      check("mid_rst_ocupacion", ocupacion, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_err", err_timeout, 0);
      check("mid_rst_start", mult_start, 0);
      check("mid_rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s0 = starts;
      repeat (40) @(posedge clk);
      #1;
      check("late_fin_no_start", starts, s0);
      check("late_fin_no_out", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete, %0d failed so far", fails);
      $fatal(1, "bench time limit");
   end

endmodule
